// File: rtl/multi_lane_fifo.sv
// multi_lane_fifo: circular FIFO with variable-width write and pop per cycle.
// Ports:
//   clk, rstn           clock, synchronous active-low reset
//   clear               synchronous flush of pointers, level and error flags
//   wen, wcount, din    write request, words offered, write lanes (lane 0 oldest)
//   ren, rcount         pop request, words to pop
//   dout, dout_valid    oldest PAR_READ words (lane 0 = head) and their valid bits
//   level               current occupancy
//   w_accept, r_accept  combinational commit indications for this cycle
//   full, empty, almost_full, almost_empty   occupancy status
//   overflow, underflow sticky rejected-write / rejected-pop flags
module multi_lane_fifo #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned PAR_WRITE  = 2,
    parameter int unsigned PAR_READ   = 3,
    parameter int unsigned DEPTH      = 5,
    parameter int unsigned AF_LEVEL   = DEPTH - 1,
    parameter int unsigned AE_LEVEL   = 1
) (
    input  logic                               clk,
    input  logic                               rstn,
    input  logic                               clear,
    input  logic                               wen,
    input  logic [$clog2(PAR_WRITE+1)-1:0]     wcount,
    input  logic [PAR_WRITE*DATA_WIDTH-1:0]    din,
    input  logic                               ren,
    input  logic [$clog2(PAR_READ+1)-1:0]      rcount,
    output logic [PAR_READ*DATA_WIDTH-1:0]     dout,
    output logic [PAR_READ-1:0]                dout_valid,
    output logic [$clog2(DEPTH+1)-1:0]         level,
    output logic                               w_accept,
    output logic                               r_accept,
    output logic                               full,
    output logic                               empty,
    output logic                               almost_full,
    output logic                               almost_empty,
    output logic                               overflow,
    output logic                               underflow
);

    localparam int unsigned LVL_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wptr;
    logic [PTR_W-1:0]      rptr;
    logic [31:0]           lvl32;
    logic [31:0]           free32;
    logic [31:0]           wc32;
    logic [31:0]           rc32;
    logic                  wr_req;
    logic                  rd_req;

    // Pointer advance modulo DEPTH; operands never exceed DEPTH so one subtract suffices.
    function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input int unsigned n);
        int unsigned s;
        s = 32'(p) + n;
        if (s >= DEPTH) s = s - DEPTH;
        return PTR_W'(s);
    endfunction

    // Acceptance and occupancy status, all from registered level.
    always_comb begin
        lvl32        = 32'(level);
        free32       = DEPTH - lvl32;
        wc32         = 32'(wcount);
        rc32         = 32'(rcount);
        wr_req       = wen && (wc32 != 32'd0);
        rd_req       = ren && (rc32 != 32'd0);
        w_accept     = !clear && wr_req && (wc32 <= PAR_WRITE) && (wc32 <= free32);
        r_accept     = !clear && rd_req && (rc32 <= PAR_READ) && (rc32 <= lvl32);
        full         = free32 < PAR_WRITE;
        empty        = lvl32 == 32'd0;
        almost_full  = lvl32 >= AF_LEVEL;
        almost_empty = lvl32 <= AE_LEVEL;
    end

    // Zero-latency read window starting at the head.
    always_comb begin
        dout       = '0;
        dout_valid = '0;
        for (int unsigned i = 0; i < PAR_READ; i++) begin
            if (i < lvl32) begin
                dout_valid[i]                     = 1'b1;
                dout[i*DATA_WIDTH +: DATA_WIDTH]  = mem[ptr_add(rptr, i)];
            end
        end
    end

    // Pointers, level and sticky error flags.
    always_ff @(posedge clk) begin
        if (!rstn || clear) begin
            wptr      <= '0;
            rptr      <= '0;
            level     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (w_accept) wptr <= ptr_add(wptr, wc32);
            if (r_accept) rptr <= ptr_add(rptr, rc32);
            level <= LVL_W'(lvl32 + (w_accept ? wc32 : 32'd0) - (r_accept ? rc32 : 32'd0));
            if (wr_req && !w_accept) overflow  <= 1'b1;
            if (rd_req && !r_accept) underflow <= 1'b1;
        end
    end

    // Storage array; deliberately not reset.
    always_ff @(posedge clk) begin
        if (rstn && w_accept) begin
            for (int unsigned i = 0; i < PAR_WRITE; i++) begin
                if (i < wc32) mem[ptr_add(wptr, i)] <= din[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_multi_lane_fifo.sv
// Self-checking bench for multi_lane_fifo (default parameters), queue-based reference model.
module tb_multi_lane_fifo;

    localparam int DW = 16;
    localparam int PW = 2;
    localparam int PR = 3;
    localparam int D  = 5;

    logic        clk = 1'b0;
    logic        rstn, clear, wen, ren;
    logic [1:0]  wcount, rcount;
    logic [31:0] din;
    logic [47:0] dout;
    logic [2:0]  dout_valid;
    logic [2:0]  level;
    logic        w_accept, r_accept, full, empty, almost_full, almost_empty, overflow, underflow;

    int checks = 0;
    int errors = 0;

    logic [15:0] q[$];
    bit          m_ov, m_un;

    always #5 clk = ~clk;

    multi_lane_fifo dut (
        .clk(clk), .rstn(rstn), .clear(clear), .wen(wen), .wcount(wcount), .din(din),
        .ren(ren), .rcount(rcount), .dout(dout), .dout_valid(dout_valid), .level(level),
        .w_accept(w_accept), .r_accept(r_accept), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .overflow(overflow), .underflow(underflow)
    );

    typedef struct {
        bit          clr;
        bit          we;
        logic [1:0]  wc;
        logic [31:0] d;
        bit          re;
        logic [1:0]  rc;
        bit          e_wa;
        bit          e_ra;
        logic [2:0]  e_lvl;
        bit          e_full;
        bit          e_ov;
        bit          e_un;
        bit          chk_d;
        logic [47:0] e_dout;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare all level-derived outputs against the model queue.
    task automatic check_outputs();
        logic [47:0] ed;
        logic [2:0]  ev;
        int          n;
        n  = q.size();
        ed = '0;
        ev = '0;
        for (int i = 0; i < PR; i++) begin
            if (i < n) begin
                ed[i*DW +: DW] = q[i];
                ev[i]          = 1'b1;
            end
        end
        check("level",        64'(level),        64'(n));
        check("empty",        64'(empty),        64'(n == 0));
        check("full",         64'(full),         64'((D - n) < PW));
        check("almost_full",  64'(almost_full),  64'(n >= D - 1));
        check("almost_empty", 64'(almost_empty), 64'(n <= 1));
        check("dout",         64'(dout),         64'(ed));
        check("dout_valid",   64'(dout_valid),   64'(ev));
        check("overflow",     64'(overflow),     64'(m_ov));
        check("underflow",    64'(underflow),    64'(m_un));
    endtask

    // One clock cycle: drive, check pre-edge state and accepts, clock, update model.
    task automatic cycle(input bit c, input bit we, input logic [1:0] wc, input logic [31:0] d,
                         input bit re, input logic [1:0] rc, output bit act_wa, output bit act_ra);
        bit ewa, era;
        int n;
        clear = c; wen = we; wcount = wc; din = d; ren = re; rcount = rc;
        n   = q.size();
        ewa = !c && we && (wc != 0) && (int'(wc) <= PW) && (int'(wc) <= D - n);
        era = !c && re && (rc != 0) && (int'(rc) <= PR) && (int'(rc) <= n);
        #1;
        check_outputs();
        check("w_accept", 64'(w_accept), 64'(ewa));
        check("r_accept", 64'(r_accept), 64'(era));
        act_wa = w_accept;
        act_ra = r_accept;
        @(posedge clk);
        if (c) begin
            q.delete();
            m_ov = 1'b0;
            m_un = 1'b0;
        end else begin
            if (era) repeat (int'(rc)) void'(q.pop_front());
            if (ewa) for (int i = 0; i < int'(wc); i++) q.push_back(d[i*DW +: DW]);
            if (we && wc != 0 && !ewa) m_ov = 1'b1;
            if (re && rc != 0 && !era) m_un = 1'b1;
        end
        #1;
    endtask

    // Reset with active requests to show reset dominates them.
    task automatic do_reset();
        rstn = 1'b0; clear = 1'b0; wen = 1'b1; wcount = 2'd1; din = 32'h1234_5678;
        ren = 1'b1; rcount = 2'd1;
        repeat (2) @(posedge clk);
        #1;
        q.delete();
        m_ov = 1'b0;
        m_un = 1'b0;
        rstn = 1'b1; wen = 1'b0; ren = 1'b0;
        #1;
        check_outputs();
    endtask

    initial begin
        bit wa, ra;
        vec_t v;

        vecs[0]  = '{0, 1, 2'd2, {16'hA001, 16'hA000}, 0, 2'd0, 1, 0, 3'd2, 0, 0, 0, 0, 48'h0};
        vecs[1]  = '{0, 1, 2'd2, {16'hB001, 16'hB000}, 0, 2'd0, 1, 0, 3'd4, 1, 0, 0, 0, 48'h0};
        vecs[2]  = '{0, 1, 2'd1, {16'h0000, 16'hC000}, 0, 2'd0, 1, 0, 3'd5, 1, 0, 0, 1,
                     {16'hB000, 16'hA001, 16'hA000}};
        vecs[3]  = '{0, 1, 2'd1, {16'h0000, 16'hEEEE}, 0, 2'd0, 0, 0, 3'd5, 1, 1, 0, 0, 48'h0};
        vecs[4]  = '{0, 1, 2'd2, {16'hE001, 16'hE000}, 1, 2'd3, 0, 1, 3'd2, 0, 1, 0, 0, 48'h0};
        vecs[5]  = '{0, 1, 2'd2, {16'hD001, 16'hD000}, 0, 2'd0, 1, 0, 3'd4, 1, 1, 0, 1,
                     {16'hD000, 16'hC000, 16'hB001}};
        vecs[6]  = '{0, 0, 2'd0, 32'h0,                1, 2'd3, 0, 1, 3'd1, 0, 1, 0, 0, 48'h0};
        vecs[7]  = '{0, 0, 2'd0, 32'h0,                1, 2'd2, 0, 0, 3'd1, 0, 1, 1, 0, 48'h0};
        vecs[8]  = '{1, 1, 2'd1, 32'h0000_1111,        1, 2'd1, 0, 0, 3'd0, 0, 0, 0, 0, 48'h0};
        vecs[9]  = '{0, 1, 2'd3, 32'h2222_3333,        0, 2'd0, 0, 0, 3'd0, 0, 1, 0, 0, 48'h0};
        vecs[10] = '{0, 1, 2'd0, 32'h4444_5555,        1, 2'd0, 0, 0, 3'd0, 0, 1, 0, 0, 48'h0};
        vecs[11] = '{0, 0, 2'd0, 32'h0,                1, 2'd1, 0, 0, 3'd0, 0, 1, 1, 0, 48'h0};
        vecs[12] = '{1, 0, 2'd0, 32'h0,                0, 2'd0, 0, 0, 3'd0, 0, 0, 0, 0, 48'h0};
        vecs[13] = '{0, 1, 2'd1, {16'h0000, 16'hF000}, 1, 2'd1, 1, 0, 3'd1, 0, 0, 1, 0, 48'h0};
        vecs[14] = '{1, 0, 2'd0, 32'h0,                0, 2'd0, 0, 0, 3'd0, 0, 0, 0, 0, 48'h0};

        do_reset();

        // Directed table
        for (int i = 0; i < 15; i++) begin
            v = vecs[i];
            cycle(v.clr, v.we, v.wc, v.d, v.re, v.rc, wa, ra);
            check("tbl_w_accept", 64'(wa),        64'(v.e_wa));
            check("tbl_r_accept", 64'(ra),        64'(v.e_ra));
            check("tbl_level",    64'(level),     64'(v.e_lvl));
            check("tbl_full",     64'(full),      64'(v.e_full));
            check("tbl_overflow", 64'(overflow),  64'(v.e_ov));
            check("tbl_underflow",64'(underflow), 64'(v.e_un));
            if (v.chk_d) check("tbl_dout", 64'(dout), 64'(v.e_dout));
        end

        // Steady stream at level 3: one in, one out, across several wraps
        cycle(0, 1, 2'd2, {16'h0101, 16'h0100}, 0, 2'd0, wa, ra);
        cycle(0, 1, 2'd1, {16'h0000, 16'h0102}, 0, 2'd0, wa, ra);
        for (int k = 0; k < 20; k++) begin
            check("stream_level", 64'(level), 64'(3));
            check("stream_head",  64'(dout[15:0]), 64'(16'(16'h0100 + k)));
            cycle(0, 1, 2'd1, {16'h0000, 16'(16'h0103 + k)}, 1, 2'd1, wa, ra);
        end
        check("stream_level_end", 64'(level), 64'(3));

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            cycle(($urandom_range(0, 39) == 0), 1'($urandom), 2'($urandom), $urandom,
                  1'($urandom), 2'($urandom), wa, ra);
        end

        // Reset in the middle of traffic
        cycle(0, 1, 2'd2, 32'hAAAA_5555, 0, 2'd0, wa, ra);
        do_reset();
        for (int n = 0; n < 50; n++) begin
            cycle(1'b0, 1'($urandom), 2'($urandom), $urandom, 1'($urandom), 2'($urandom), wa, ra);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_lane_fifo.md
Name: multi_lane_fifo

Overview:
- Parametrised successor to the single-rate circular FIFO used between the global buffer and the PE scratch pads.
- Accepts a variable number of words per cycle, from 0 to PAR_WRITE, and releases a variable number per cycle, from 0 to PAR_READ.
- Arbitrary (non power-of-two) DEPTH; tracks occupancy with an explicit level counter instead of a spare slot.
- Adds programmable almost-full/almost-empty thresholds and sticky overflow/underflow flags so the PE controller can schedule ahead.

Parameters:
- DATA_WIDTH, 16, bits per word
- PAR_WRITE, 2, maximum words written per cycle (>=1)
- PAR_READ, 3, maximum words read per cycle (>=1)
- DEPTH, 5, storage words (>= max(PAR_WRITE, PAR_READ)), any integer
- AF_LEVEL, DEPTH-1, almost_full asserted when level >= AF_LEVEL
- AE_LEVEL, 1, almost_empty asserted when level <= AE_LEVEL

Ports:
- clk  in  1  clock, all state on rising edge
- rstn  in  1  synchronous, active-low reset
- clear  in  1  synchronous flush of pointers, level and error flags
- wen  in  1  write request
- wcount  in  $clog2(PAR_WRITE+1)  words offered this cycle
- din  in  PAR_WRITE*DATA_WIDTH  write lanes; lane 0 = bits [DATA_WIDTH-1:0], oldest
- ren  in  1  read (pop) request
- rcount  in  $clog2(PAR_READ+1)  words to pop this cycle
- dout  out  PAR_READ*DATA_WIDTH  oldest PAR_READ words; lane 0 = head
- dout_valid  out  PAR_READ  lane i valid iff i < level
- level  out  $clog2(DEPTH+1)  current occupancy
- w_accept  out  1  combinational: this cycle's write will commit
- r_accept  out  1  combinational: this cycle's pop will commit
- full  out  1  free < PAR_WRITE
- empty  out  1  level == 0
- almost_full  out  1  level >= AF_LEVEL
- almost_empty  out  1  level <= AE_LEVEL
- overflow  out  1  sticky: a write was rejected
- underflow  out  1  sticky: a pop was rejected

Behaviour:
- Reset: rstn, clk, synchronous, active-low. When low at an edge: wptr, rptr, level <= 0; overflow, underflow <= 0. Storage array is not reset.
- Reset output values: level=0, empty=1, full=(PAR_WRITE>DEPTH ? 1 : 0), i.e. 0 for legal params; almost_empty=1; almost_full=(AF_LEVEL==0); dout_valid=0; dout=0.
- Priority: rstn > clear > wen/ren. With clear high, the next state equals the reset state and wen/ren are ignored; w_accept and r_accept read 0.
- free = DEPTH - level, evaluated from registered level at cycle start. A same-cycle pop gives no write credit.
- w_accept = wen & (wcount != 0) & (wcount <= PAR_WRITE) & (wcount <= free).
- r_accept = ren & (rcount != 0) & (rcount <= PAR_READ) & (rcount <= level).
- Transactions are all-or-nothing; no partial acceptance.
- Write: lanes 0..wcount-1 are stored at (wptr+i) mod DEPTH, then wptr <= (wptr+wcount) mod DEPTH. Wrap uses compare-and-subtract, valid for any DEPTH.
- Pop: rptr <= (rptr+rcount) mod DEPTH.
- Level update: level <= level + (w_accept ? wcount : 0) - (r_accept ? rcount : 0). Both may commit in the same cycle.
- Read path is combinational, zero latency: dout lane i = mem[(rptr+i) mod DEPTH] if i < level, else 0. Data written in cycle N is visible on dout in cycle N+1.
- Rejected write: wen=1 but w_accept=0 with wcount != 0 (including wcount > PAR_WRITE). Sets overflow; no other state changes.
- Rejected pop: ren=1 but r_accept=0 with rcount != 0. Sets underflow.
- wen or ren with a count of 0 is a no-op and sets no flag.
- overflow and underflow clear only on rstn or clear.
- full, empty, almost_full, almost_empty and dout_valid are functions of registered level only.

Test Plan:
- Reset, defaults (DW=16, PW=2, PR=3, D=5) -> level=0, empty=1, full=0, almost_empty=1, dout=0, dout_valid=000.
- Write {A1,A0}, then {B1,B0}, then {C0} with wcount=1 -> level=5, full=1, dout lanes = A0,A1,B0, dout_valid=111.
- Full with level 5, wen wcount=1 -> w_accept=0, overflow=1, level stays 5.
- Pop rcount=3 while writing 2 at level 5 -> write rejected (free=0), pop commits, level=2. Next cycle write 2 -> wptr wraps 0→2, dout = B1,C0,new0.
- Level 1, ren rcount=2 -> underflow=1, level 1. Then clear -> level=0, underflow=0.
- Level 3: write 1 and pop 1 simultaneously for 20 cycles with an incrementing pattern -> level stays 3, dout lane 0 tracks the sequence in order across multiple wraps.
